// File: rtl/ag32gbd_ahb_buf_reader_if.sv
//==============================================================================
// ag32gbd_ahb_buf_reader_if : AHB-Lite bus bundle for the image-buffer reader
// Rev 1.0
//==============================================================================
`default_nettype none

interface ag32gbd_ahb_buf_reader_if;
  logic [1:0]  mem_ahb_htrans;
  logic        mem_ahb_hready;
  logic        mem_ahb_hwrite;
  logic [31:0] mem_ahb_haddr;
  logic [2:0]  mem_ahb_hsize;
  logic [31:0] mem_ahb_hwdata;
  logic        mem_ahb_hreadyout;
  logic        mem_ahb_hresp;
  logic [31:0] mem_ahb_hrdata;

  modport master (
    output mem_ahb_htrans, mem_ahb_hready, mem_ahb_hwrite, mem_ahb_haddr,
           mem_ahb_hsize, mem_ahb_hwdata,
    input  mem_ahb_hreadyout, mem_ahb_hresp, mem_ahb_hrdata
  );

  modport slave (
    input  mem_ahb_htrans, mem_ahb_hready, mem_ahb_hwrite, mem_ahb_haddr,
           mem_ahb_hsize, mem_ahb_hwdata,
    output mem_ahb_hreadyout, mem_ahb_hresp, mem_ahb_hrdata
  );
endinterface

`default_nettype wire

// File: rtl/ag32gbd_ahb_buf_reader.sv
//==============================================================================
// ag32gbd_ahb_buf_reader : AHB-Lite slave reading the 2bpp image buffer + STATUS/CTRL
// Rev 1.0
//==============================================================================
`default_nettype none

module ag32gbd_ahb_buf_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter int          TIMEOUT   = 64
) (
  input  logic                    sys_clock,
  input  logic                    resetn,
  ag32gbd_ahb_buf_reader_if.slave ahb,
  output logic                    RequestReadBuffer,
  output logic [9:0]              ReadBufferOffset,
  input  logic [7:0]              BufferReadResult,
  input  logic                    BufferDataReady,
  input  logic                    Cam_Capture,
  input  logic                    BlockDataReady,
  output logic                    Irq
);

  localparam int c_WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REG  = 3'd1,
    S_REQ  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4,
    S_ERR1 = 3'd5,
    S_ERR2 = 3'd6
  } state_t;

  state_t              state_q,     state_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q,     hresp_d;
  logic [31:0]         hrdata_q,    hrdata_d;
  logic                req_q,       req_d;
  logic [9:0]          offset_q,    offset_d;
  logic [31:0]         acc_q,       acc_d;
  logic [1:0]          left_q,      left_d;
  logic [c_WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic [11:0]         addr_q,      addr_d;
  logic                write_q,     write_d;
  logic                sticky_q,    sticky_d;
  logic [7:0]          blk_cnt_q,   blk_cnt_d;
  logic                irq_en_q,    irq_en_d;
  logic                irq_q,       irq_d;
  logic                blk_prev_q,  blk_prev_d;

  logic        w_rise;
  logic        w_ctrl_wr;
  logic        w_clr;
  logic        w_accept;
  logic        w_buf_rd;
  logic [9:0]  w_start;
  logic [1:0]  w_left;
  logic [31:0] w_acc_next;
  logic [31:0] w_reg_rdata;
  logic        unused_bits;

  assign unused_bits = ^{ahb.mem_ahb_hwdata[31:2], ahb.mem_ahb_htrans[0]};

  assign w_rise    = BlockDataReady & ~blk_prev_q;
  assign w_ctrl_wr = (state_q == S_REG) && write_q && (addr_q == 12'h404);
  assign w_clr     = w_ctrl_wr && ahb.mem_ahb_hwdata[0];

  // A new block edge wins over a simultaneous firmware clear.
  always_comb begin
    sticky_d   = w_rise | (sticky_q & ~w_clr);
    blk_cnt_d  = blk_cnt_q + {7'd0, w_rise};
    irq_en_d   = w_ctrl_wr ? ahb.mem_ahb_hwdata[1] : irq_en_q;
    irq_d      = irq_en_q & sticky_q;
    blk_prev_d = BlockDataReady;
  end

  assign w_accept = ahb.mem_ahb_hready && ahb.mem_ahb_htrans[1] &&
                    (ahb.mem_ahb_haddr[31:12] == BASE_ADDR[31:12]) &&
                    ((state_q == S_IDLE) || (state_q == S_REG) || (state_q == S_DONE));
  assign w_buf_rd = !ahb.mem_ahb_hwrite && (ahb.mem_ahb_haddr[11:10] == 2'b00);

  always_comb begin
    case (ahb.mem_ahb_hsize)
      3'd0:    begin w_start = ahb.mem_ahb_haddr[9:0];                w_left = 2'd0; end
      3'd1:    begin w_start = {ahb.mem_ahb_haddr[9:1], 1'b0};        w_left = 2'd1; end
      default: begin w_start = {ahb.mem_ahb_haddr[9:2], 2'b00};       w_left = 2'd3; end
    endcase
  end

  // Register reads see the post-update values so a pipelined write just before is visible.
  always_comb begin
    case (ahb.mem_ahb_haddr[11:0])
      12'h400: w_reg_rdata = {16'd0, blk_cnt_d, 6'd0, sticky_d, Cam_Capture};
      12'h404: w_reg_rdata = {30'd0, irq_en_d, 1'b0};
      default: w_reg_rdata = 32'd0;
    endcase
  end

  // Aligned accesses never cross a word, so the offset's low bits select the lane.
  assign w_acc_next = acc_q | ({24'd0, BufferReadResult} << {offset_q[1:0], 3'b000});

  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = 1'b0;
    hrdata_d    = hrdata_q;
    req_d       = req_q;
    offset_d    = offset_q;
    acc_d       = acc_q;
    left_d      = left_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;

    case (state_q)
      S_REQ: begin
        if (BufferDataReady) begin
          acc_d = w_acc_next;
          req_d = 1'b0;
          if (left_q == 2'd0) begin
            state_d     = S_DONE;
            hreadyout_d = 1'b1;
            hrdata_d    = w_acc_next;
          end else begin
            state_d = S_GAP;
            left_d  = left_q - 2'd1;
          end
        end else if (wait_cnt_q == c_WAIT_W'(TIMEOUT - 1)) begin
          state_d  = S_ERR1;
          req_d    = 1'b0;
          hresp_d  = 1'b1;
          hrdata_d = 32'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + c_WAIT_W'(1);
        end
      end
      S_GAP: begin
        state_d    = S_REQ;
        req_d      = 1'b1;
        offset_d   = offset_q + 10'd1;
        wait_cnt_d = '0;
      end
      S_ERR1: begin
        state_d     = S_ERR2;
        hresp_d     = 1'b1;
        hreadyout_d = 1'b1;
      end
      S_ERR2: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        if (w_accept) begin
          addr_d  = ahb.mem_ahb_haddr[11:0];
          write_d = ahb.mem_ahb_hwrite;
          if (w_buf_rd) begin
            state_d     = S_REQ;
            hreadyout_d = 1'b0;
            req_d       = 1'b1;
            offset_d    = w_start;
            left_d      = w_left;
            acc_d       = 32'd0;
            wait_cnt_d  = '0;
          end else begin
            state_d = S_REG;
            if (!ahb.mem_ahb_hwrite) begin
              hrdata_d = w_reg_rdata;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
      req_q       <= 1'b0;
      offset_q    <= 10'd0;
      acc_q       <= 32'd0;
      left_q      <= 2'd0;
      wait_cnt_q  <= '0;
      addr_q      <= 12'd0;
      write_q     <= 1'b0;
      sticky_q    <= 1'b0;
      blk_cnt_q   <= 8'd0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      blk_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      req_q       <= req_d;
      offset_q    <= offset_d;
      acc_q       <= acc_d;
      left_q      <= left_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      sticky_q    <= sticky_d;
      blk_cnt_q   <= blk_cnt_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      blk_prev_q  <= blk_prev_d;
    end
  end

  assign ahb.mem_ahb_hreadyout = hreadyout_q;
  assign ahb.mem_ahb_hresp     = hresp_q;
  assign ahb.mem_ahb_hrdata    = hrdata_q;
  assign RequestReadBuffer     = req_q;
  assign ReadBufferOffset      = offset_q;
  assign Irq                   = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_ag32gbd_ahb_buf_reader.sv
//==============================================================================
// tb_ag32gbd_ahb_buf_reader : self-checking bench with bram model and AHB driver
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_ag32gbd_ahb_buf_reader;

  localparam logic [31:0] c_BASE = 32'h6000_0000;

  logic       sys_clock = 1'b0;
  logic       resetn    = 1'b0;
  logic       RequestReadBuffer;
  logic [9:0] ReadBufferOffset;
  logic [7:0] BufferReadResult;
  logic       BufferDataReady;
  logic       Cam_Capture    = 1'b0;
  logic       BlockDataReady = 1'b0;
  logic       Irq;

  always #5 sys_clock = ~sys_clock;

  ag32gbd_ahb_buf_reader_if ahb ();
  assign ahb.mem_ahb_hready = ahb.mem_ahb_hreadyout;

  ag32gbd_ahb_buf_reader #(
    .BASE_ADDR (c_BASE),
    .TIMEOUT   (64)
  ) dut (
    .sys_clock         (sys_clock),
    .resetn            (resetn),
    .ahb               (ahb),
    .RequestReadBuffer (RequestReadBuffer),
    .ReadBufferOffset  (ReadBufferOffset),
    .BufferReadResult  (BufferReadResult),
    .BufferDataReady   (BufferDataReady),
    .Cam_Capture       (Cam_Capture),
    .BlockDataReady    (BlockDataReady),
    .Irq               (Irq)
  );

  // bram model: ready in the second cycle of each request
  logic [7:0] mem [1024];
  logic [9:0] off_log [$];
  int         req_cyc      = 0;
  int         req_high_cnt = 0;
  bit         bram_en      = 1'b1;

  assign BufferDataReady  = bram_en && RequestReadBuffer && (req_cyc >= 1);
  assign BufferReadResult = mem[ReadBufferOffset];

  always @(posedge sys_clock) begin
    if (RequestReadBuffer && !BufferDataReady) req_cyc <= req_cyc + 1;
    else                                       req_cyc <= 0;
    if (RequestReadBuffer) req_high_cnt <= req_high_cnt + 1;
    if (RequestReadBuffer && BufferDataReady) off_log.push_back(ReadBufferOffset);
  end

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    string       name;
    logic        rd;
    logic [31:0] data;
    logic        resp;
  } exp_t;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [2:0]  size;
    logic [31:0] mem_word;
    logic [31:0] exp_data;
    logic [9:0]  exp_first;
    int          nbytes;
    int          exp_waits;
  } vec_t;

  cmd_t cmd_q [$];
  exp_t exp_q [$];
  vec_t vecs  [7];

  int n_tests    = 0;
  int n_fail     = 0;
  int last_waits = 0;
  bit saw_err1   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [11:0] a, input logic [2:0] s, input logic [31:0] d,
                         input logic resp, input string name);
    cmd_t c;
    exp_t e;
    c = '{addr: a, size: s, wr: 1'b0, wdata: 32'd0};
    e = '{name: name, rd: 1'b1, data: d, resp: resp};
    cmd_q.push_back(c);
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] wd, input string name);
    cmd_t c;
    exp_t e;
    c = '{addr: a, size: 3'd2, wr: 1'b1, wdata: wd};
    e = '{name: name, rd: 1'b0, data: 32'd0, resp: 1'b0};
    cmd_q.push_back(c);
    exp_q.push_back(e);
  endtask

  task automatic check_result();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got a response, expected none");
      return;
    end
    e = exp_q.pop_front();
    chk({e.name, "_hresp"}, 32'(ahb.mem_ahb_hresp), 32'(e.resp));
    if (e.rd) chk(e.name, ahb.mem_ahb_hrdata, e.data);
  endtask

  // Issues queued transfers back-to-back; the next address phase rides the last data-phase cycle.
  task automatic ahb_run();
    cmd_t c;
    bit   busy;
    bit   hold;
    int   guard;
    busy  = 1'b0;
    guard = 0;
    @(negedge sys_clock);
    while (busy || cmd_q.size() > 0) begin
      hold = 1'b0;
      if (busy) begin
        if (!ahb.mem_ahb_hreadyout) begin
          last_waits++;
          if (ahb.mem_ahb_hresp) saw_err1 = 1'b1;
          guard++;
          if (guard > 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_timeout: hreadyout still 0 after %0d cycles, required 1", guard);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            cmd_q.delete();
            busy = 1'b0;
          end else begin
            @(negedge sys_clock);
          end
          continue;
        end
        check_result();
        hold = ahb.mem_ahb_hresp;
        busy = 1'b0;
      end
      if (!hold && cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        ahb.mem_ahb_htrans = 2'b10;
        ahb.mem_ahb_haddr  = c_BASE | {20'd0, c.addr};
        ahb.mem_ahb_hsize  = c.size;
        ahb.mem_ahb_hwrite = c.wr;
        busy       = 1'b1;
        last_waits = 0;
        saw_err1   = 1'b0;
        guard      = 0;
        @(posedge sys_clock);
        #1;
        ahb.mem_ahb_htrans = 2'b00;
        ahb.mem_ahb_hwdata = c.wdata;
        @(negedge sys_clock);
      end else if (cmd_q.size() > 0) begin
        @(negedge sys_clock);
      end
    end
    @(posedge sys_clock);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clock);
      BlockDataReady = 1'b1;
      @(negedge sys_clock);
      BlockDataReady = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         base;
    int         rq0;
    logic [9:0] a;

    vecs[0] = '{"word010",  12'h010, 3'd2, 32'h44332211, 32'h44332211, 10'h010, 4, 11};
    vecs[1] = '{"byte103",  12'h103, 3'd0, 32'hA5776655, 32'hA5000000, 10'h103, 1, 2};
    vecs[2] = '{"half3FE",  12'h3FE, 3'd1, 32'hBEEF1234, 32'hBEEF0000, 10'h3FE, 2, 5};
    vecs[3] = '{"half201",  12'h201, 3'd1, 32'hDDCCBBAA, 32'h0000BBAA, 10'h200, 2, 5};
    vecs[4] = '{"word087",  12'h087, 3'd2, 32'h87654321, 32'h87654321, 10'h084, 4, 11};
    vecs[5] = '{"size7_0F0",12'h0F0, 3'd7, 32'hCAFEF00D, 32'hCAFEF00D, 10'h0F0, 4, 11};
    vecs[6] = '{"byte001",  12'h001, 3'd0, 32'h00005A00, 32'h00005A00, 10'h001, 1, 2};

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    ahb.mem_ahb_htrans = 2'b00;
    ahb.mem_ahb_hwrite = 1'b0;
    ahb.mem_ahb_haddr  = 32'd0;
    ahb.mem_ahb_hsize  = 3'd0;
    ahb.mem_ahb_hwdata = 32'd0;

    repeat (3) @(negedge sys_clock);
    chk("rst_hreadyout", 32'(ahb.mem_ahb_hreadyout), 32'd1);
    chk("rst_hresp",     32'(ahb.mem_ahb_hresp),     32'd0);
    chk("rst_hrdata",    ahb.mem_ahb_hrdata,         32'd0);
    chk("rst_request",   32'(RequestReadBuffer),     32'd0);
    chk("rst_offset",    32'(ReadBufferOffset),      32'd0);
    chk("rst_irq",       32'(Irq),                   32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      for (int k = 0; k < 4; k++) begin
        a = {vecs[i].addr[9:2], 2'b00} + 10'(k);
        mem[a] = vecs[i].mem_word[8*k +: 8];
      end
      base = off_log.size();
      push_rd(vecs[i].addr, vecs[i].size, vecs[i].exp_data, 1'b0, vecs[i].name);
      ahb_run();
      chk({vecs[i].name, "_waits"}, 32'(last_waits), 32'(vecs[i].exp_waits));
      chk({vecs[i].name, "_nreq"}, 32'(off_log.size() - base), 32'(vecs[i].nbytes));
      for (int k = 0; k < vecs[i].nbytes && base + k < off_log.size(); k++) begin
        a = vecs[i].exp_first + 10'(k);
        chk({vecs[i].name, "_off"}, 32'(off_log[base + k]), 32'(a));
      end
    end

    bram_en = 1'b0;
    rq0 = req_high_cnt;
    push_rd(12'h040, 3'd2, 32'd0, 1'b1, "timeout");
    ahb_run();
    chk("timeout_req_cycles", 32'(req_high_cnt - rq0), 32'd64);
    chk("timeout_err1_seen",  32'(saw_err1),           32'd1);
    chk("timeout_waits",      32'(last_waits),         32'd65);
    bram_en = 1'b1;

    push_rd(12'h010, 3'd2, 32'h44332211, 1'b0, "pipe_w0");
    push_rd(12'h084, 3'd2, 32'h87654321, 1'b0, "pipe_w1");
    push_rd(12'h404, 3'd2, 32'h00000000, 1'b0, "pipe_ctrl");
    ahb_run();

    rq0 = req_high_cnt;
    push_wr(12'h020, 32'hFFFF_FFFF, "wr_buf");
    ahb_run();
    chk("wr_buf_noreq", 32'(req_high_cnt - rq0), 32'd0);
    chk("wr_buf_waits", 32'(last_waits),         32'd0);

    Cam_Capture = 1'b1;
    pulse(3);
    push_wr(12'h404, 32'h0000_0002, "ctrl_en");
    push_rd(12'h400, 3'd2, 32'h0000_0303, 1'b0, "status3");
    push_rd(12'h404, 3'd2, 32'h0000_0002, 1'b0, "ctrl_rd");
    ahb_run();
    chk("irq_set", 32'(Irq), 32'd1);

    push_wr(12'h404, 32'h0000_0003, "ctrl_clr");
    push_rd(12'h400, 3'd2, 32'h0000_0301, 1'b0, "status_clr");
    ahb_run();
    chk("irq_clr", 32'(Irq), 32'd0);

    // clear and block edge land in the same cycle
    @(negedge sys_clock);
    ahb.mem_ahb_htrans = 2'b10;
    ahb.mem_ahb_haddr  = c_BASE | 32'h404;
    ahb.mem_ahb_hsize  = 3'd2;
    ahb.mem_ahb_hwrite = 1'b1;
    @(posedge sys_clock);
    #1;
    ahb.mem_ahb_htrans = 2'b00;
    ahb.mem_ahb_hwdata = 32'h0000_0003;
    BlockDataReady     = 1'b1;
    @(posedge sys_clock);
    #1;
    BlockDataReady     = 1'b0;
    ahb.mem_ahb_hwrite = 1'b0;
    push_rd(12'h400, 3'd2, 32'h0000_0403, 1'b0, "status_setwins");
    ahb_run();
    chk("irq_setwins", 32'(Irq), 32'd1);

    @(negedge sys_clock);
    ahb.mem_ahb_htrans = 2'b10;
    ahb.mem_ahb_haddr  = c_BASE | 32'h010;
    ahb.mem_ahb_hsize  = 3'd2;
    ahb.mem_ahb_hwrite = 1'b0;
    @(posedge sys_clock);
    #1;
    ahb.mem_ahb_htrans = 2'b00;
    chk("rst_mid_req_before", 32'(RequestReadBuffer), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_req_drop",  32'(RequestReadBuffer),     32'd0);
    chk("rst_mid_hreadyout", 32'(ahb.mem_ahb_hreadyout), 32'd1);
    repeat (2) @(negedge sys_clock);
    resetn = 1'b1;
    push_rd(12'h010, 3'd2, 32'h44332211, 1'b0, "after_rst_read");
    ahb_run();

    pulse(256);
    push_rd(12'h400, 3'd2, 32'h0000_0003, 1'b0, "status_wrap");
    push_rd(12'h404, 3'd2, 32'h0000_0000, 1'b0, "ctrl_after_rst");
    ahb_run();
    chk("irq_after_rst", 32'(Irq), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
